// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: op codes, FSM states and
// small helpers used by both the datapath and the serial shifter.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = $clog2(XLEN);

  localparam logic [3:0] ALUAdd  = 4'd0;
  localparam logic [3:0] ALUSub  = 4'd1;
  localparam logic [3:0] ALUSLL  = 4'd2;
  localparam logic [3:0] ALUSLT  = 4'd3;
  localparam logic [3:0] ALUSLTU = 4'd4;
  localparam logic [3:0] ALUXOR  = 4'd5;
  localparam logic [3:0] ALUSRL  = 4'd6;
  localparam logic [3:0] ALUSRA  = 4'd7;
  localparam logic [3:0] ALUOR   = 4'd8;
  localparam logic [3:0] ALUAND  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALUSLL) || (op == ALUSRL) || (op == ALUSRA);
  endfunction

  // One step of the serial shifter; non-shift codes pass the value through.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0] op,
                                                 input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    case (op)
      ALUSLL:  r = {v[XLEN-2:0], 1'b0};
      ALUSRL:  r = {1'b0, v[XLEN-1:1]};
      ALUSRA:  r = {v[XLEN-1], v[XLEN-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_exec_unit_if;

  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               alu_op;
  logic [alu_pkg::XLEN-1:0] op_a;
  logic [alu_pkg::XLEN-1:0] op_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [alu_pkg::XLEN-1:0] result;
  logic                     zero;
  logic                     illegal_op;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );

endinterface

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU operations. Shift codes return the source operand unchanged,
// which is exactly the result of a shift by zero.
module alu_comb_ops
  import alu_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res,
  output logic            illegal
);

  // Operation select; undefined codes yield zero and flag illegal.
  always_comb begin
    res     = {XLEN{1'b0}};
    illegal = 1'b0;
    case (op)
      ALUAdd:  res = a + b;
      ALUSub:  res = a - b;
      ALUSLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALUSLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      ALUXOR:  res = a ^ b;
      ALUOR:   res = a | b;
      ALUAND:  res = a & b;
      ALUSLL,
      ALUSRL,
      ALUSRA:  res = a;
      default: begin
        res     = {XLEN{1'b0}};
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops plus a one-bit-per-cycle serial shifter,
// with valid/ready on both the operand and the result side.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  state_t            state_r;
  state_t            next_state_s;
  logic [XLEN-1:0]   shreg_r;
  logic [SHW-1:0]    cnt_r;
  logic [3:0]        sh_op_r;
  logic [XLEN-1:0]   result_r;
  logic              zero_r;
  logic              illegal_r;
  logic [XLEN-1:0]   comb_res_s;
  logic              comb_ill_s;
  logic [SHW-1:0]    amt_s;
  logic              accept_s;
  logic              start_shift_s;
  logic [XLEN-1:0]   step_s;
  logic              in_ready_s;
  logic              out_valid_s;

  alu_comb_ops u_comb (
    .op      (bus.alu_op),
    .a       (bus.op_a),
    .b       (bus.op_b),
    .res     (comb_res_s),
    .illegal (comb_ill_s)
  );

  assign amt_s         = bus.op_b[SHW-1:0];
  assign accept_s      = bus.in_valid && (state_r == ST_IDLE);
  assign start_shift_s = is_shift(bus.alu_op) && (amt_s != {SHW{1'b0}});
  assign step_s        = shift_step(sh_op_r, shreg_r);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = start_shift_s ? ST_SHIFT : ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r <= SHW'(1)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE:  in_ready_s  = 1'b1;
      ST_SHIFT: in_ready_s  = 1'b0;
      ST_DONE:  out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, serial shift and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r   <= {XLEN{1'b0}};
      cnt_r     <= {SHW{1'b0}};
      sh_op_r   <= 4'd0;
      result_r  <= {XLEN{1'b0}};
      zero_r    <= 1'b1;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && start_shift_s) begin
            shreg_r <= bus.op_a;
            cnt_r   <= amt_s;
            sh_op_r <= bus.alu_op;
          end else if (accept_s) begin
            result_r  <= comb_res_s;
            zero_r    <= (comb_res_s == {XLEN{1'b0}});
            illegal_r <= comb_ill_s;
          end
        end
        ST_SHIFT: begin
          shreg_r <= step_s;
          cnt_r   <= cnt_r - SHW'(1);
          // The last step lands directly in the result register.
          if (cnt_r <= SHW'(1)) begin
            result_r  <= step_s;
            zero_r    <= (step_s == {XLEN{1'b0}});
            illegal_r <= 1'b0;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.result     = result_r;
  assign bus.zero       = zero_r;
  assign bus.illegal_op = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  bit   hold_low;
  bit   rnd_ready;
  bit   prev_ov;
  bit   prev_hs;
  exp_t sbq[$];

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic ill, input int lat);
    exp_t e;
    e.res = res;
    e.ill = ill;
    e.lat = lat;
    e.acc = 0;
    return e;
  endfunction

  // Reference model from the arithmetic rules, independent of the RTL structure.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int amt;
    amt = int'(b[4:0]);
    case (op)
      4'd0: return mk(a + b, 1'b0, 1);
      4'd1: return mk(a - b, 1'b0, 1);
      4'd2: return mk(a << amt, 1'b0, 1 + amt);
      4'd3: return mk(($signed(a) < $signed(b)) ? 32'd1 : 32'd0, 1'b0, 1);
      4'd4: return mk((a < b) ? 32'd1 : 32'd0, 1'b0, 1);
      4'd5: return mk(a ^ b, 1'b0, 1);
      4'd6: return mk(a >> amt, 1'b0, 1 + amt);
      4'd7: return mk(32'($signed(a) >>> amt), 1'b0, 1 + amt);
      4'd8: return mk(a | b, 1'b0, 1);
      4'd9: return mk(a & b, 1'b0, 1);
      default: return mk(32'd0, 1'b1, 1);
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stuck low, required 1");
    end
    e.acc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Consumer side: out_ready changes just after the rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) bus.out_ready = 1'b0;
      else if (rnd_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
      else bus.out_ready = 1'b1;
    end
  end

  // Monitor: compares every presented result against the queue front.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        check("in_ready_while_valid", 32'(bus.in_ready), 32'd0);
        if (sbq.size() == 0) begin
          check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          if (!prev_ov) check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
          check("result", bus.result, sbq[0].res);
          check("zero", 32'(bus.zero), 32'(sbq[0].res == 32'd0));
          check("illegal_op", 32'(bus.illegal_op), 32'(sbq[0].ill));
          if (bus.out_ready) void'(sbq.pop_front());
        end
      end else if (prev_hs) begin
        check("idle_after_handshake", 32'(bus.in_ready), 32'd1);
      end
      prev_hs = bus.out_valid && bus.out_ready;
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    hold_low  = 1'b0;
    rnd_ready = 1'b0;
    rst_n     = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op   = 4'd0;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_illegal", 32'(bus.illegal_op), 32'd0);
    rst_n = 1'b1;

    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 1'b0, 1));
    issue(4'd1, 32'd5, 32'd5, mk(32'h0, 1'b0, 1));
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, mk(32'd1, 1'b0, 1));
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1'b0, 1));
    issue(4'd7, 32'h8000_0000, 32'h0000_0104, mk(32'hF800_0000, 1'b0, 5));
    issue(4'd6, 32'h8000_0000, 32'h0000_0104, mk(32'h0800_0000, 1'b0, 5));
    issue(4'd2, 32'd1, 32'd31, mk(32'h8000_0000, 1'b0, 32));
    issue(4'd2, 32'h1234, 32'h20, mk(32'h1234, 1'b0, 1));
    issue(4'hF, 32'hDEAD_BEEF, 32'h1, mk(32'h0, 1'b1, 1));
    drain();

    // Backpressure: result held for 10 cycles, then released.
    hold_low = 1'b1;
    issue(4'd5, 32'hA5A5_0F0F, 32'h5A5A_0F0F, mk(32'hFFFF_0000, 1'b0, 1));
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (10) @(negedge clk);
    check("bp_still_valid", 32'(bus.out_valid), 32'd1);
    hold_low = 1'b0;
    drain();
    issue(4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, mk(32'h00F0_00F0, 1'b0, 1));
    drain();

    // Asynchronous reset in the middle of a long shift.
    issue(4'd2, 32'h0000_0003, 32'd20, mk(32'h0030_0000, 1'b0, 21));
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_result", bus.result, 32'd0);
    check("arst_zero", 32'(bus.zero), 32'd1);
    sbq.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Random operations with random consumer stalls.
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3)) << 30 | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) b = a;
      issue(op, a, b, model(op, a, b));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rnd_ready = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU operation code produced by the instruction decoder. Takes two operands plus alu_op over a valid/ready handshake and returns the result over a second valid/ready handshake.
- Non-shift ops complete in 1 cycle.
- SLL/SRL/SRA use an area-saving serial shifter: one bit per cycle.
- Sits between decode/operand-fetch and writeback in the multi-cycle core.

Parameters:
- XLEN, 32, operand/result width.
- SHW, $clog2(XLEN), shift-amount width (5 for XLEN=32).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and alu_op valid.
- in_ready  output  1  unit can accept a new operation.
- alu_op  input  4  operation code (alu_pkg encoding).
- op_a  input  XLEN  first operand; shift source for shifts.
- op_b  input  XLEN  second operand; shift amount is op_b[SHW-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0; used for branch resolution.
- illegal_op  output  1  alu_op was not a defined code; qualified by out_valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal_op=0, shift counter=0.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid&&in_ready in cycle N captures alu_op, op_a, op_b.
- Non-shift op or shift with amount 0: go to DONE. result valid in cycle N+1.
- Shift with amount k>0: load shift register with op_a, counter=k, go to SHIFT.
  - Each SHIFT cycle shifts 1 bit. SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates MSB.
  - Counter decrements each SHIFT cycle. When it reaches 0, go to DONE.
  - out_valid first high in cycle N+1+k. Worst case is k=31 → N+32.
- Arithmetic:
  - ADD/SUB: modulo 2^XLEN, no overflow flag.
  - SLT: signed compare → {0..,1} or 0.
  - SLTU: unsigned compare.
  - XOR/OR/AND: bitwise.
  - Only op_b[SHW-1:0] is used for shifts; upper bits are ignored.
- Undefined alu_op: result=0, illegal_op=1, 1-cycle latency.
- DONE: result, zero and illegal_op are held stable while out_valid=1 and out_ready=0 (backpressure, unlimited). out_valid&&out_ready → IDLE next cycle.
- Throughput: no accept in the same cycle as a DONE handshake. Max 1 op per 2 cycles.
- in_valid while in_ready=0 is ignored. The upstream must hold its inputs; inputs are not sampled.
- zero is derived from the registered result and is valid whenever out_valid=1.
- Asynchronous reset mid-SHIFT or in DONE: immediately return to reset values. The in-flight operation is discarded, with no output handshake.
- in_valid deasserted by upstream in IDLE: no state change.

Decomposition:
- Package alu_pkg:
  - ALU op localparams, 4 bits: ALUAdd=0, ALUSub=1, ALUSLL=2, ALUSLT=3, ALUSLTU=4, ALUXOR=5, ALUSRL=6, ALUSRA=7, ALUOR=8, ALUAND=9.
  - State encoding: IDLE, SHIFT, DONE.
  - Helper function is_shift(op).
- Sub-module alu_comb_ops: purely combinational non-shift ops. Inputs op, a, b; outputs res and illegal.
- Top holds the FSM, shift register, counter and output registers.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 → result=0x80000000 at N+1, zero=0. SUB 5-5 → result=0, zero=1.
- SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- SRA a=0x80000000, b=0x0000_0104 (amount 4) → out_valid first at N+5, result=0xF8000000. SRL with the same operands → 0x08000000. SLL a=1, amount 31 → 0x80000000 at N+32.
- Shift amount 0 (SLL a=0x1234, b=0x20) → result=0x1234 at N+1. Only low 5 bits are used.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. result, zero and out_valid are stable and in_ready=0. Release → IDLE next cycle, new op accepted.
- Illegal op 4'hF → result=0, illegal_op=1. Separately, assert rst_n=0 mid-SLL (amount 20, cycle 5) → out_valid=0 and in_ready=1 immediately, no spurious result after release.
